// File: rtl/neopx_stream_tx.sv
// -----------------------------------------------------------------------------
// neopx_stream_tx
//
// Serialises AXI-Stream pixel words onto a single-wire NeoPixel line
// (WS2812 / SK6812 style).  Each bit is sent as a high phase followed by a
// low phase.  The lengths of both phases depend on the bit value.  The MSB of
// the pixel goes first.  When the last pixel of a frame has been sent, the
// line is held low for RESET_CNT clocks so that the LED chain latches the
// frame.  A one-cycle o_frame_done pulse then marks the return to idle.
//
// Parameters
//   BITS_PER_PIXEL : 24 (RGB) or 32 (RGBW); no other value is legal
//   T0H / T1H      : high time in clocks for a '0' / '1' bit
//   T0L / T1L      : low time in clocks for a '0' / '1' bit
//   RESET_CNT      : low time in clocks of the frame latch
//   CNT_W          : timing counter width; each timing value must be >= 1
//                    and must fit in CNT_W bits
//
// Ports
//   axis_aclk     in   single clock
//   axis_reset    in   asynchronous active-high reset
//   s_axis_data   in   pixel word, right-aligned (bits above the pixel ignored)
//   s_axis_valid  in   pixel valid
//   s_axis_last   in   last pixel of a frame
//   s_axis_ready  out  high only while idle and out of reset
//   o_serial      out  registered NeoPixel line
//   o_busy        out  high whenever a pixel or latch is in progress
//   o_frame_done  out  one-cycle pulse on the first idle cycle after a latch
// -----------------------------------------------------------------------------
module neopx_stream_tx #(
    parameter int BITS_PER_PIXEL = 24,
    parameter int T0H            = 29,
    parameter int T1H            = 58,
    parameter int T0L            = 62,
    parameter int T1L            = 33,
    parameter int RESET_CNT      = 6600,
    parameter int CNT_W          = 16
) (
    input  logic        axis_aclk,
    input  logic        axis_reset,
    input  logic [31:0] s_axis_data,
    input  logic        s_axis_valid,
    input  logic        s_axis_last,
    output logic        s_axis_ready,
    output logic        o_serial,
    output logic        o_busy,
    output logic        o_frame_done
);

    localparam int IDX_W = $clog2(BITS_PER_PIXEL);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BITS_PER_PIXEL - 1);

    // The counter is loaded with T-1 and the phase ends when it reads zero,
    // so every phase lasts exactly T clocks and the counter never wraps.
    localparam logic [CNT_W-1:0] T0H_M1 = CNT_W'(T0H - 1);
    localparam logic [CNT_W-1:0] T1H_M1 = CNT_W'(T1H - 1);
    localparam logic [CNT_W-1:0] T0L_M1 = CNT_W'(T0L - 1);
    localparam logic [CNT_W-1:0] T1L_M1 = CNT_W'(T1L - 1);
    localparam logic [CNT_W-1:0] RST_M1 = CNT_W'(RESET_CNT - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        HIGH  = 2'd1,
        LOW   = 2'd2,
        LATCH = 2'd3
    } state_t;

    state_t                    state;
    logic [CNT_W-1:0]          cnt;
    logic [IDX_W-1:0]          bit_idx;
    logic [BITS_PER_PIXEL-1:0] shift_reg;
    logic                      last_flag;
    logic                      xfer;

    // The bits of s_axis_data above the pixel width are not used.
    logic                      unused_data;

    function automatic logic [CNT_W-1:0] high_load(input logic b);
        return b ? T1H_M1 : T0H_M1;
    endfunction

    function automatic logic [CNT_W-1:0] low_load(input logic b);
        return b ? T1L_M1 : T0L_M1;
    endfunction

    // Ready is gated by reset directly, so it is low while reset is held.
    // It rises in the first cycle after reset is released.
    assign s_axis_ready = (state == IDLE) && !axis_reset;
    assign xfer         = s_axis_valid && s_axis_ready;
    assign o_busy       = (state != IDLE);
    assign unused_data  = ^s_axis_data;

    always_ff @(posedge axis_aclk or posedge axis_reset) begin
        if (axis_reset) begin
            state        <= IDLE;
            cnt          <= '0;
            bit_idx      <= '0;
            shift_reg    <= '0;
            last_flag    <= 1'b0;
            o_serial     <= 1'b0;
            o_frame_done <= 1'b0;
        end else begin
            o_frame_done <= 1'b0;
            case (state)
                IDLE: begin
                    o_serial <= 1'b0;
                    if (xfer) begin
                        shift_reg <= s_axis_data[BITS_PER_PIXEL-1:0];
                        last_flag <= s_axis_last;
                        bit_idx   <= '0;
                        cnt       <= high_load(s_axis_data[BITS_PER_PIXEL-1]);
                        o_serial  <= 1'b1;
                        state     <= HIGH;
                    end
                end

                HIGH: begin
                    if (cnt == '0) begin
                        cnt      <= low_load(shift_reg[BITS_PER_PIXEL-1]);
                        o_serial <= 1'b0;
                        state    <= LOW;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end

                LOW: begin
                    if (cnt == '0) begin
                        if (bit_idx == LAST_IDX) begin
                            if (last_flag) begin
                                cnt   <= RST_M1;
                                state <= LATCH;
                            end else begin
                                cnt   <= '0;
                                state <= IDLE;
                            end
                        end else begin
                            // The next bit starts in the very next cycle.
                            // Its timing is taken from the bit that is
                            // about to move into the MSB position.
                            bit_idx   <= bit_idx + 1'b1;
                            shift_reg <= {shift_reg[BITS_PER_PIXEL-2:0], 1'b0};
                            cnt       <= high_load(shift_reg[BITS_PER_PIXEL-2]);
                            o_serial  <= 1'b1;
                            state     <= HIGH;
                        end
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end

                LATCH: begin
                    if (cnt == '0) begin
                        o_frame_done <= 1'b1;
                        state        <= IDLE;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end

                default: begin
                    o_serial <= 1'b0;
                    cnt      <= '0;
                    state    <= IDLE;
                end
            endcase
        end
    end

endmodule
